// File: rtl/hiscore_ram_arbiter_if.sv
// Bus bundle between the CPU RAM decode, the hiscore engine, the work RAM and the arbiter.
// The arbiter takes the slave view; the surrounding logic or a bench takes the master view.
`timescale 1ns/1ps

interface hiscore_ram_arbiter_if #(
  parameter int AW = 12
);
  logic          cpu_ram_cs;
  logic          cpu_ram_we;
  logic [AW-1:0] cpu_ram_addr;
  logic [7:0]    cpu_ram_din;
  logic [7:0]    cpu_ram_dout;

  logic          hs_req;
  logic          hs_we;
  logic [AW-1:0] hs_addr;
  logic [7:0]    hs_din;
  logic [7:0]    hs_dout;
  logic          hs_ack;

  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [7:0]    ram_din;
  logic [7:0]    ram_dout;

  logic          cpu_pause_req;
  logic          cpu_paused;
  logic          cpu_conflict;

  modport slave (
    input  cpu_ram_cs, cpu_ram_we, cpu_ram_addr, cpu_ram_din,
    output cpu_ram_dout,
    input  hs_req, hs_we, hs_addr, hs_din,
    output hs_dout, hs_ack,
    output ram_addr, ram_we, ram_din,
    input  ram_dout,
    output cpu_pause_req, cpu_conflict,
    input  cpu_paused
  );

  modport master (
    output cpu_ram_cs, cpu_ram_we, cpu_ram_addr, cpu_ram_din,
    input  cpu_ram_dout,
    output hs_req, hs_we, hs_addr, hs_din,
    input  hs_dout, hs_ack,
    input  ram_addr, ram_we, ram_din,
    output ram_dout,
    input  cpu_pause_req, cpu_conflict,
    output cpu_paused
  );
endinterface

// File: rtl/hiscore_ram_arbiter.sv
// Work-RAM arbiter: the CPU owns the port by default, the hiscore engine gets idle cycles,
// and a request starved for MAX_WAIT cycles escalates to a CPU pause handshake.
`timescale 1ns/1ps

module hiscore_ram_arbiter #(
  parameter int AW       = 12,
  parameter int MAX_WAIT = 255
) (
  input logic               clk,
  input logic               reset,
  hiscore_ram_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DATA  = 2'd3;

  // A MAX_WAIT of 0 disables escalation; the counter keeps a 1-bit floor so it stays legal.
  localparam bit              PAUSE_EN  = (MAX_WAIT != 0);
  localparam int              CW        = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0]   WAIT_LAST = (MAX_WAIT > 0) ? CW'(MAX_WAIT - 1) : '0;
  localparam logic [CW-1:0]   CNT_SAT   = '1;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_SAT) ? v : v + CW'(1);
  endfunction

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [CW-1:0] wait_cnt;
  logic          grant;

  logic          req_we_p0;
  logic [AW-1:0] req_addr_p0;
  logic [7:0]    req_din_p0;

  logic          vld_p1;
  logic [7:0]    dout_p1;
  logic          pause_req;
  logic          conflict;

  assign grant = ((state == S_WAIT)  && !bus.cpu_ram_cs) ||
                 ((state == S_PAUSE) &&  bus.cpu_paused);

  always_comb begin
    bus.ram_addr = bus.cpu_ram_addr;
    bus.ram_din  = bus.cpu_ram_din;
    bus.ram_we   = bus.cpu_ram_cs & bus.cpu_ram_we;
    if (grant) begin
      bus.ram_addr = req_addr_p0;
      bus.ram_din  = req_din_p0;
      bus.ram_we   = req_we_p0;
    end
  end

  assign bus.cpu_ram_dout  = bus.ram_dout;
  assign bus.hs_dout       = dout_p1;
  assign bus.hs_ack        = vld_p1;
  assign bus.cpu_pause_req = pause_req;
  assign bus.cpu_conflict  = conflict;

  // CPU keeps the port on a simultaneous request; only an idle CPU cycle or a granted pause lets hiscore in.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.hs_req) state_nxt = S_WAIT;
      S_WAIT: begin
        if (!bus.cpu_ram_cs)
          state_nxt = S_DATA;
        else if (PAUSE_EN && (wait_cnt == WAIT_LAST))
          state_nxt = S_PAUSE;
      end
      S_PAUSE: if (bus.cpu_paused) state_nxt = S_DATA;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stage p0: request capture, wait counting and pause/conflict control
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      req_we_p0   <= 1'b0;
      req_addr_p0 <= '0;
      req_din_p0  <= '0;
      pause_req   <= 1'b0;
      conflict    <= 1'b0;
    end else begin
      state <= state_nxt;

      if ((state == S_IDLE) && bus.hs_req) begin
        req_we_p0   <= bus.hs_we;
        req_addr_p0 <= bus.hs_addr;
        req_din_p0  <= bus.hs_din;
        wait_cnt    <= '0;
      end else if ((state == S_WAIT) && bus.cpu_ram_cs) begin
        wait_cnt <= sat_inc(wait_cnt);
      end

      // Pause is raised only on entry to PAUSE and held until the access has completed.
      if ((state == S_WAIT) && (state_nxt == S_PAUSE))
        pause_req <= 1'b1;
      else if (state == S_DATA)
        pause_req <= 1'b0;

      if ((state == S_PAUSE) && grant && bus.cpu_ram_cs)
        conflict <= 1'b1;
    end
  end

  // Stage p1: RAM read data returns in DATA; writes leave the last read value in place
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      dout_p1 <= '0;
    end else begin
      vld_p1 <= (state == S_DATA);
      if ((state == S_DATA) && !req_we_p0)
        dout_p1 <= bus.ram_dout;
    end
  end

endmodule
